// File: rtl/fdc_disk_responder.sv
// Disk-side responder for the nec765 disk_sr/disk_cr link: decodes seek, read-ID, read and
// write requests and moves 512-byte sectors between a flat image memory and the FDC FIFOs.
module fdc_disk_responder #(
  parameter int          TRACKS    = 40,
  parameter int          SPT       = 9,
  parameter logic [7:0]  SECT_BASE = 8'hC1,
  parameter int          SIDES     = 1,
  parameter int          ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       disk_sr,
  output logic [31:0]       disk_cr,
  output logic [7:0]        disk_data_in,
  output logic              disk_data_clkin,
  input  logic [7:0]        disk_data_out,
  output logic              disk_data_clkout,
  input  logic [1:0]        img_present,
  input  logic [1:0]        img_wp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_SEEK, S_RID, S_RD_MEM, S_RD_PUSH, S_WR_POP, S_WR_MEM, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_SEEK, OP_RID, OP_READ, OP_WRITE} op_t;

  localparam logic [31:0] SECT_END = 32'(SECT_BASE) + 32'(SPT);
  localparam logic [7:0]  RID_LAST = 8'(32'(SECT_BASE) + 32'(SPT) - 32'd1);

  state_t            state;
  op_t               op;
  logic              drv;
  logic [6:0]        cyl_q;
  logic              req_err;
  logic [6:0]        track [2];
  logic [7:0]        rid_ctr [2];
  logic [8:0]        idx;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        seek_done;
  logic              err_q;
  logic              wp_q;
  logic              op_done;
  logic              cr_h;
  logic [6:0]        cr_c;
  logic [7:0]        cr_r;

  logic [6:0]        dec_c;
  logic              dec_h;
  logic [7:0]        dec_r;
  logic              geom_err;
  logic              sect_err;
  logic              dec_err;
  logic [31:0]       lba_c;
  logic [ADDR_W-1:0] base_c;
  logic [8:0]        idx_next;
  logic [ADDR_W-1:0] idx_ext;
  logic [ADDR_W-1:0] idx_next_ext;
  logic              unused_bits;

  assign dec_c = disk_sr[14:8];
  assign dec_h = disk_sr[15];
  assign dec_r = disk_sr[7:0];

  assign idx_next     = idx + 9'd1;
  assign idx_ext      = {{(ADDR_W-9){1'b0}}, idx};
  assign idx_next_ext = {{(ADDR_W-9){1'b0}}, idx_next};

  assign unused_bits = ^{disk_sr[31:26], disk_sr[19], track[0], track[1]};

  // Sector ID is only range-checked for data transfers; writes also honour write-protect.
  always_comb begin
    geom_err = !img_present[drv] || (32'(dec_c) >= TRACKS) || (32'(dec_h) >= SIDES);
    sect_err = (dec_r < SECT_BASE) || (32'(dec_r) >= SECT_END);
    dec_err  = geom_err;
    case (op)
      OP_SEEK:  dec_err = geom_err;
      OP_RID:   dec_err = geom_err;
      OP_READ:  dec_err = geom_err || sect_err;
      OP_WRITE: dec_err = geom_err || sect_err || img_wp[drv];
      default:  dec_err = geom_err;
    endcase
    lba_c  = ((32'(drv) * 32'(SIDES) + 32'(dec_h)) * 32'(TRACKS) + 32'(dec_c)) * 32'(SPT)
             + 32'(dec_r) - 32'(SECT_BASE);
    base_c = ADDR_W'(lba_c << 9);
  end

  assign disk_cr = {cr_r, 1'b0, cr_c, 7'b0, cr_h, 1'b0, img_present,
                    op_done, err_q, wp_q, seek_done};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      op               <= OP_SEEK;
      drv              <= 1'b0;
      cyl_q            <= '0;
      req_err          <= 1'b0;
      track[0]         <= '0;
      track[1]         <= '0;
      rid_ctr[0]       <= SECT_BASE;
      rid_ctr[1]       <= SECT_BASE;
      idx              <= '0;
      base_q           <= '0;
      seek_done        <= '0;
      err_q            <= 1'b0;
      wp_q             <= 1'b0;
      op_done          <= 1'b0;
      cr_h             <= 1'b0;
      cr_c             <= '0;
      cr_r             <= '0;
      mem_addr         <= '0;
      mem_rd           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_wdata        <= '0;
      disk_data_in     <= '0;
      disk_data_clkin  <= 1'b0;
      disk_data_clkout <= 1'b0;
    end else begin
      disk_data_clkin  <= 1'b0;
      disk_data_clkout <= 1'b0;
      case (state)
        // Priority: seek > readid > read > write, drive 0 before drive 1.
        S_IDLE: begin
          if (|disk_sr[25:17]) begin
            state <= S_DECODE;
            if (disk_sr[24] || disk_sr[25]) begin
              op  <= OP_SEEK;
              drv <= !disk_sr[24];
            end else if (disk_sr[22] || disk_sr[23]) begin
              op  <= OP_RID;
              drv <= !disk_sr[22];
            end else if (disk_sr[17] || disk_sr[18]) begin
              op  <= OP_READ;
              drv <= !disk_sr[17];
            end else if (disk_sr[20] || disk_sr[21]) begin
              op  <= OP_WRITE;
              drv <= !disk_sr[20];
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DECODE: begin
          cyl_q   <= dec_c;
          req_err <= dec_err;
          wp_q    <= img_wp[drv];
          base_q  <= base_c;
          idx     <= '0;
          cr_h    <= dec_h;
          cr_c    <= dec_c;
          cr_r    <= dec_r;
          case (op)
            OP_SEEK: state <= S_SEEK;
            OP_RID:  state <= S_RID;
            OP_READ: begin
              if (dec_err) begin
                err_q   <= 1'b1;
                op_done <= 1'b1;
                state   <= S_DONE;
              end else begin
                mem_addr <= base_c;
                mem_rd   <= 1'b1;
                state    <= S_RD_MEM;
              end
            end
            OP_WRITE: begin
              if (dec_err) begin
                err_q   <= 1'b1;
                op_done <= 1'b1;
                state   <= S_DONE;
              end else begin
                disk_data_clkout <= 1'b1;
                state            <= S_WR_POP;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
        S_SEEK: begin
          if (!req_err) track[drv] <= cyl_q;
          seek_done[drv] <= 1'b1;
          err_q          <= req_err;
          state          <= S_DONE;
        end
        S_RID: begin
          err_q   <= req_err;
          op_done <= 1'b1;
          if (!req_err) begin
            cr_r         <= rid_ctr[drv];
            rid_ctr[drv] <= (rid_ctr[drv] == RID_LAST) ? SECT_BASE : rid_ctr[drv] + 8'd1;
          end
          state <= S_DONE;
        end
        S_RD_MEM: begin
          if (mem_ready) begin
            mem_rd          <= 1'b0;
            disk_data_in    <= mem_rdata;
            disk_data_clkin <= 1'b1;
            state           <= S_RD_PUSH;
          end
        end
        S_RD_PUSH: begin
          if (idx == 9'd511) begin
            op_done <= 1'b1;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else begin
            idx      <= idx_next;
            mem_addr <= base_q + idx_next_ext;
            mem_rd   <= 1'b1;
            state    <= S_RD_MEM;
          end
        end
        // The pop strobe is high during this cycle, so the FIFO head is taken before it advances.
        S_WR_POP: begin
          mem_wdata <= disk_data_out;
          mem_addr  <= base_q + idx_ext;
          mem_wr    <= 1'b1;
          state     <= S_WR_MEM;
        end
        S_WR_MEM: begin
          if (mem_ready) begin
            mem_wr <= 1'b0;
            if (idx == 9'd511) begin
              op_done <= 1'b1;
              err_q   <= 1'b0;
              state   <= S_DONE;
            end else begin
              idx              <= idx_next;
              disk_data_clkout <= 1'b1;
              state            <= S_WR_POP;
            end
          end
        end
        S_DONE: begin
          if (disk_sr[16] && (disk_sr[25:17] == 9'd0)) begin
            op_done   <= 1'b0;
            err_q     <= 1'b0;
            seek_done <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdc_disk_responder.sv
// Directed bench for fdc_disk_responder: table of single-shot requests plus hand-written
// read, write and mid-transfer reset sequences against a small memory and FIFO model.
module tb_fdc_disk_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out;
  logic        disk_data_clkout;
  logic [1:0]  img_present;
  logic [1:0]  img_wp;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  fdc_disk_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .disk_sr          (disk_sr),
    .disk_cr          (disk_cr),
    .disk_data_in     (disk_data_in),
    .disk_data_clkin  (disk_data_clkin),
    .disk_data_out    (disk_data_out),
    .disk_data_clkout (disk_data_clkout),
    .img_present      (img_present),
    .img_wp           (img_wp),
    .mem_addr         (mem_addr),
    .mem_rd           (mem_rd),
    .mem_wr           (mem_wr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ready        (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image memory: reads return addr[7:0]^A5, writes land in wmem; latency 1..4 cycles by address.
  logic [7:0] wmem [0:(1<<20)-1];
  int         rd_addr_log [0:4095];
  int         rd_cnt   = 0;
  int         wr_cnt   = 0;
  int         wait_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end else begin
      mem_ready <= 1'b0;
      if ((mem_rd || mem_wr) && !mem_ready) begin
        if (wait_cnt >= int'(mem_addr[1:0])) begin
          mem_ready <= 1'b1;
          wait_cnt  <= 0;
          mem_rdata <= mem_addr[7:0] ^ 8'hA5;
          if (mem_wr) begin
            wmem[mem_addr] <= mem_wdata;
            wr_cnt         <= wr_cnt + 1;
          end
          if (mem_rd) begin
            if (rd_cnt < 4096) rd_addr_log[rd_cnt] <= int'(mem_addr);
            rd_cnt <= rd_cnt + 1;
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // FDC side: capture pushed bytes, advance the write FIFO on pops, watch strobe spacing.
  logic [7:0] rx_mem [0:4095];
  int         rx_cnt     = 0;
  int         fifo_ptr   = 0;
  int         fifo_base  = 0;
  int         viol_cnt   = 0;
  logic       prev_clkin  = 1'b0;
  logic       prev_clkout = 1'b0;

  assign disk_data_out = 8'(fifo_ptr - fifo_base);

  always @(posedge clk) begin
    if (disk_data_clkin) begin
      if (rx_cnt < 4096) rx_mem[rx_cnt] <= disk_data_in;
      rx_cnt <= rx_cnt + 1;
    end
    if (disk_data_clkout) fifo_ptr <= fifo_ptr + 1;
    if ((disk_data_clkin && prev_clkin) || (disk_data_clkout && prev_clkout) || (mem_rd && mem_wr))
      viol_cnt <= viol_cnt + 1;
    prev_clkin  <= disk_data_clkin;
    prev_clkout <= disk_data_clkout;
  end

  typedef struct {
    string       name;
    logic [31:0] sr;
    logic [1:0]  present;
    logic [1:0]  wp;
    logic [31:0] exp_cr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] req(input int bit_no, input logic [6:0] c, input logic h,
                                      input logic [7:0] r);
    return (32'd1 << bit_no) | {16'b0, h, c, r};
  endfunction

  function automatic void add_vec(input string n, input logic [31:0] sr, input logic [1:0] p,
                                  input logic [1:0] w, input logic [31:0] e);
    vec_t v;
    v.name    = n;
    v.sr      = sr;
    v.present = p;
    v.wp      = w;
    v.exp_cr  = e;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] sr, input logic [1:0] pres,
                               input logic [1:0] wp);
    @(negedge clk);
    disk_sr     = sr;
    img_present = pres;
    img_wp      = wp;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!(disk_cr[4] || disk_cr[1:0] != 2'b00) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic ackRequest(input string name);
    applyStimulus(32'h0001_0000, img_present, img_wp);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_ack_clear"}, disk_cr & 32'h0000_001B, 32'h0);
    applyStimulus(32'h0, 2'b11, 2'b00);
    @(negedge clk);
  endtask

  int rd0, wr0, rx0, po0, bad, n;

  initial begin
    rst_n       = 1'b0;
    disk_sr     = 32'h0;
    img_present = 2'b10;
    img_wp      = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("reset_cr_present10", disk_cr, 32'h0000_0040);
    checkOutput("reset_mem_outputs", {2'b0, mem_addr, disk_data_in, mem_rd, mem_wr}, 32'h0);
    checkOutput("reset_strobes", {22'b0, mem_wdata, disk_data_clkin, disk_data_clkout}, 32'h0);
    img_present = 2'b11;
    #1;
    checkOutput("reset_cr_present11", disk_cr, 32'h0000_0060);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    add_vec("seek_d0_c5",      req(24, 7'd5,  1'b0, 8'h12), 2'b11, 2'b00, 32'h1205_0061);
    add_vec("seek_d1_c39",     req(25, 7'd39, 1'b0, 8'h00), 2'b11, 2'b00, 32'h0027_0062);
    add_vec("seek_d0_c40_err", req(24, 7'd40, 1'b0, 8'h00), 2'b11, 2'b00, 32'h0028_0069);
    add_vec("seek_d1_absent",  req(25, 7'd3,  1'b0, 8'h00), 2'b01, 2'b00, 32'h0003_002A);
    add_vec("seek_d0_h1_err",  req(24, 7'd2,  1'b1, 8'h00), 2'b11, 2'b00, 32'h0002_0169);
    for (int k = 0; k < 10; k++)
      add_vec($sformatf("rid_d0_%0d", k), req(22, 7'd2, 1'b0, 8'h00), 2'b11, 2'b00,
              {8'(8'hC1 + 8'(k % 9)), 24'h02_00_70});
    add_vec("rid_both_d0_wins", req(22, 7'd0, 1'b0, 8'h00) | (32'd1 << 23), 2'b11, 2'b00,
            32'hC200_0070);
    add_vec("rid_d1_h1_err",   req(23, 7'd0,  1'b1, 8'h55), 2'b11, 2'b00, 32'h5500_0178);
    add_vec("rid_d1_first",    req(23, 7'd7,  1'b0, 8'h00), 2'b11, 2'b00, 32'hC107_0070);
    add_vec("seek_beats_read", req(25, 7'd4,  1'b0, 8'hC1) | (32'd1 << 17), 2'b11, 2'b00,
            32'hC104_0062);
    add_vec("read_r_ca_err",   req(17, 7'd0,  1'b0, 8'hCA), 2'b11, 2'b00, 32'hCA00_0078);
    add_vec("read_r_c0_err",   req(17, 7'd0,  1'b0, 8'hC0), 2'b11, 2'b00, 32'hC000_0078);
    add_vec("read_c40_err",    req(17, 7'd40, 1'b0, 8'hC1), 2'b11, 2'b00, 32'hC128_0078);
    add_vec("read_d0_absent",  req(17, 7'd0,  1'b0, 8'hC1), 2'b10, 2'b00, 32'hC100_0058);
    add_vec("write_d0_wp",     req(20, 7'd1,  1'b0, 8'hC1), 2'b11, 2'b01, 32'hC101_007C);
    add_vec("write_d1_h1_err", req(21, 7'd0,  1'b1, 8'hC3), 2'b11, 2'b00, 32'hC300_0178);
    add_vec("write_d1_wp",     req(21, 7'd1,  1'b0, 8'hC1), 2'b11, 2'b10, 32'hC101_007C);

    foreach (vecs[i]) begin
      rd0 = rd_cnt; wr0 = wr_cnt; rx0 = rx_cnt; po0 = fifo_ptr;
      applyStimulus(vecs[i].sr, vecs[i].present, vecs[i].wp);
      waitDone(vecs[i].name, 200);
      checkOutput({vecs[i].name, "_cr"}, disk_cr, vecs[i].exp_cr);
      checkOutput({vecs[i].name, "_no_activity"},
                  32'((rd_cnt - rd0) + (wr_cnt - wr0) + (rx_cnt - rx0) + (fifo_ptr - po0)), 32'h0);
      ackRequest(vecs[i].name);
    end

    // Sector read: drive 0, C0 H0 R=C2 -> LBA 1, bytes from address 512.
    rd0 = rd_cnt; wr0 = wr_cnt; rx0 = rx_cnt; po0 = fifo_ptr;
    applyStimulus(req(17, 7'd0, 1'b0, 8'hC2), 2'b11, 2'b00);
    waitDone("read_c2", 10000);
    checkOutput("read_c2_cr", disk_cr, 32'hC200_0070);
    checkOutput("read_c2_pushes", 32'(rx_cnt - rx0), 32'd512);
    checkOutput("read_c2_first_addr", 32'(rd_addr_log[rd0]), 32'd512);
    checkOutput("read_c2_last_addr", 32'(rd_addr_log[rd0 + 511]), 32'd1023);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      logic [7:0] e;
      e = 8'(k) ^ 8'hA5;
      if (rx_mem[rx0 + k] !== e) bad++;
    end
    checkOutput("read_c2_bytes", 32'(bad), 32'h0);
    checkOutput("read_c2_no_writes", 32'((wr_cnt - wr0) + (fifo_ptr - po0)), 32'h0);
    ackRequest("read_c2");

    // Sector write: drive 1, C1 H0 R=C1 -> LBA ((1*1+0)*40+1)*9 = 369, base 188928.
    rd0 = rd_cnt; wr0 = wr_cnt; rx0 = rx_cnt; po0 = fifo_ptr;
    fifo_base = fifo_ptr;
    applyStimulus(req(21, 7'd1, 1'b0, 8'hC1), 2'b11, 2'b00);
    waitDone("write_d1", 10000);
    checkOutput("write_d1_cr", disk_cr, 32'hC101_0070);
    checkOutput("write_d1_pops", 32'(fifo_ptr - po0), 32'd512);
    checkOutput("write_d1_mem_writes", 32'(wr_cnt - wr0), 32'd512);
    checkOutput("write_d1_no_reads", 32'((rd_cnt - rd0) + (rx_cnt - rx0)), 32'h0);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      logic [7:0] e;
      e = 8'(k);
      if (wmem[188928 + k] !== e) bad++;
    end
    checkOutput("write_d1_data", 32'(bad), 32'h0);
    ackRequest("write_d1");

    // Reset asserted while byte 200 of a read is being fetched.
    rx0 = rx_cnt;
    applyStimulus(req(17, 7'd0, 1'b0, 8'hC1), 2'b11, 2'b00);
    n = 0;
    while ((rx_cnt - rx0) < 200 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_reach_200", 32'(rx_cnt - rx0), 32'd200);
    checkOutput("rst_mid_rd_active", {31'b0, mem_rd}, 32'h1);
    rst_n   = 1'b0;
    disk_sr = 32'h0;
    #1;
    checkOutput("rst_mid_outputs",
                {28'b0, mem_rd, mem_wr, disk_data_clkin, disk_data_clkout}, 32'h0);
    checkOutput("rst_mid_cr", disk_cr, 32'h0000_0060);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx0 = rx_cnt;
    repeat (20) @(negedge clk);
    checkOutput("rst_mid_quiet", 32'(rx_cnt - rx0), 32'h0);

    // Fresh read after reset: drive 0, C2 R=C5 -> LBA 22, base 11264.
    rd0 = rd_cnt; rx0 = rx_cnt;
    applyStimulus(req(17, 7'd2, 1'b0, 8'hC5), 2'b11, 2'b00);
    waitDone("read_after_rst", 10000);
    checkOutput("read_after_rst_cr", disk_cr, 32'hC502_0070);
    checkOutput("read_after_rst_pushes", 32'(rx_cnt - rx0), 32'd512);
    checkOutput("read_after_rst_first_addr", 32'(rd_addr_log[rd0]), 32'd11264);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      logic [7:0] e;
      e = 8'(k) ^ 8'hA5;
      if (rx_mem[rx0 + k] !== e) bad++;
    end
    checkOutput("read_after_rst_bytes", 32'(bad), 32'h0);
    ackRequest("read_after_rst");

    checkOutput("strobe_protocol", 32'(viol_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
